timer_compare_unit: RTL and testbench
=====================================

# timer_compare_unit

Memory-mapped 32-bit timer that drives the clock prescaler's control inputs (ON, divide value) and consumes its clock-enable pulse as the count tick. Sits on the processor's peripheral bus next to the prescaler. It produces a compare-match flag and an interrupt request. Counting is single-clock and enable-qualified; no clock gating is done inside this block.

## Interface
Parameters:
- CNT_W, 32, counter/compare width (bus data width fixed at 32; unused upper read bits return 0)

Ports:
- i_clk  input  1  system clock
- i_arst  input  1  reset, asynchronous, active-high
- i_tick  input  1  clock-enable pulse from prescaler; one-cycle-wide count strobe
- i_we  input  1  bus write strobe, sampled on posedge i_clk
- i_addr  input  2  register word address
- i_wdata  input  32  bus write data
- o_rdata  output  32  read data, combinational from i_addr
- o_on  output  1  CONFIG.ON, to prescaler ON input
- o_divide_by  output  7  prescaler divide value, (2^CONFIG.DIV)-1
- o_irq  output  1  interrupt request

## Operation
- Registers:
  - addr 0 CONFIG: [0] ON, [1] AUTO (1 = auto-reload, 0 = one-shot), [2] IE, [6:4] DIV (0..7); other bits read 0.
  - addr 1 COUNT: R/W; a write loads the value.
  - addr 2 COMPARE: R/W.
  - addr 3 STATUS: [0] MATCH, write-1-to-clear; writing 0 has no effect.
- o_on = CONFIG.ON; o_divide_by = (1<<DIV)-1, giving 0,1,3,7,15,31,63,127 for DIV 0..7.
- Count event: ON=1 and i_tick=1 on a posedge.
  - COUNT≠COMPARE: COUNT <= COUNT+1, wrapping 2^CNT_W-1 -> 0 with no flag.
  - COUNT==COMPARE: MATCH <= 1.
    - AUTO=1: COUNT <= 0.
    - AUTO=0: COUNT holds and CONFIG.ON <= 0, so the prescaler stops.
- i_tick is ignored while ON=0.
- o_irq = MATCH & IE.
- Simultaneous events, same edge:
  - COUNT write and count event: the written value wins.
  - CONFIG write and one-shot auto-clear of ON: the written value wins.
  - STATUS W1C and new match: the set wins, MATCH stays 1.
  - COMPARE write and count event: the compare uses the old COMPARE value.
- Reset mid-count: all registers cleared immediately and asynchronously.

## Timing
- Reset values: CONFIG=0, COUNT=0, COMPARE=0, MATCH=0, o_on=0, o_divide_by=0, o_irq=0, o_rdata=register at i_addr (all zero).
- Write latency: a register update is visible on o_rdata and outputs one edge after the i_we edge.
- Match latency: MATCH rises on the edge that samples the matching tick.
  - o_irq is combinational from MATCH, so it is high in that same cycle.
- Auto-reload period: (COMPARE+1) ticks; the tick period is (divide_by+1) i_clk cycles.

## Configuration
- TIMER_IRQ_REG_EN defined: o_irq comes from a flop.
  - It asserts one cycle after MATCH&IE and deasserts one cycle after they drop.
  - Reset value is 0.
- Undefined: o_irq is combinational MATCH & IE, with zero added latency.

## Test plan
- Reset check:
  - Stimulus: assert i_arst mid-count with COUNT=5, ON=1.
  - Required: all outputs and o_rdata for every address read 0 immediately, before any clock edge.
- Auto-reload:
  - Setup: COMPARE=3, CONFIG=0x07 (ON, AUTO, IE, DIV=0), i_tick held 1.
  - COUNT sequence: 0,1,2,3,0,1…
  - MATCH/o_irq high on the edge where COUNT goes 3->0.
  - STATUS write 0x1 clears MATCH.
- One-shot:
  - Setup: COMPARE=2, CONFIG=0x05.
  - Required after the 3rd tick: COUNT=2 held, o_on=0, MATCH=1.
  - Further i_tick pulses leave COUNT=2.
- Divide mapping:
  - Stimulus: write DIV=0..7 in turn.
  - Required: o_divide_by = 0,1,3,7,15,31,63,127.
  - Required: o_on follows CONFIG[0].
- Collisions:
  - COUNT write 0x10 coincident with a tick: COUNT=0x10.
  - W1C coincident with a match: MATCH stays 1.
  - Wrap: COUNT=0xFFFFFFFF with COMPARE=5 goes to 0 with no MATCH.
- Macro check:
  - Stimulus: run the same scenarios with TIMER_IRQ_REG_EN defined.
  - Required: o_irq lags MATCH&IE by exactly one i_clk cycle on both edges.

Source files
------------

// File: rtl/timer_compare_unit_if.sv
// Peripheral-bus bundle for timer_compare_unit: write strobe, word address,
// write data and the combinational read data returned by the timer.
interface timer_compare_unit_if;
    logic        i_we;
    logic [1:0]  i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;

    modport master (output i_we, output i_addr, output i_wdata, input  o_rdata);
    modport slave  (input  i_we, input  i_addr, input  i_wdata, output o_rdata);
endinterface

// File: rtl/timer_compare_unit.sv
// Memory-mapped compare timer driving the prescaler (ON, divide value) and counting its tick.
// Optional TIMER_IRQ_REG_EN: registers o_irq (one cycle behind MATCH & IE).
module timer_compare_unit #(
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_arst,
    input  logic                 i_tick,
    timer_compare_unit_if.slave  bus,
    output logic                 o_on,
    output logic [6:0]           o_divide_by,
    output logic                 o_irq
);
    localparam logic [1:0] A_CONFIG  = 2'd0;
    localparam logic [1:0] A_COUNT   = 2'd1;
    localparam logic [1:0] A_COMPARE = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic             cfg_on;
    logic             cfg_auto;
    logic             cfg_ie;
    logic [2:0]       cfg_div;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] compare;
    logic             match;

    logic wr_cfg, wr_cnt, wr_cmp, wr_sts;
    logic cnt_evt, hit;

    assign wr_cfg  = bus.i_we && (bus.i_addr == A_CONFIG);
    assign wr_cnt  = bus.i_we && (bus.i_addr == A_COUNT);
    assign wr_cmp  = bus.i_we && (bus.i_addr == A_COMPARE);
    assign wr_sts  = bus.i_we && (bus.i_addr == A_STATUS);

    // The compare always sees the pre-edge COMPARE, so a same-edge write only affects later ticks.
    assign cnt_evt = cfg_on && i_tick;
    assign hit     = cnt_evt && (count == compare);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            cfg_on   <= 1'b0;
            cfg_auto <= 1'b0;
            cfg_ie   <= 1'b0;
            cfg_div  <= 3'd0;
        end else if (wr_cfg) begin
            cfg_on   <= bus.i_wdata[0];
            cfg_auto <= bus.i_wdata[1];
            cfg_ie   <= bus.i_wdata[2];
            cfg_div  <= bus.i_wdata[6:4];
        end else if (hit && !cfg_auto) begin
            cfg_on   <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            count <= '0;
        end else if (wr_cnt) begin
            count <= bus.i_wdata[CNT_W-1:0];
        end else if (hit) begin
            if (cfg_auto) count <= '0;
        end else if (cnt_evt) begin
            count <= count + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)      compare <= '0;
        else if (wr_cmp) compare <= bus.i_wdata[CNT_W-1:0];
    end

    // A new match outranks a same-edge write-1-to-clear.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)                         match <= 1'b0;
        else if (hit)                       match <= 1'b1;
        else if (wr_sts && bus.i_wdata[0])  match <= 1'b0;
    end

    always_comb begin
        bus.o_rdata = '0;
        case (bus.i_addr)
            A_CONFIG:  bus.o_rdata[6:0]       = {cfg_div, 1'b0, cfg_ie, cfg_auto, cfg_on};
            A_COUNT:   bus.o_rdata[CNT_W-1:0] = count;
            A_COMPARE: bus.o_rdata[CNT_W-1:0] = compare;
            A_STATUS:  bus.o_rdata[0]         = match;
            default:   bus.o_rdata            = '0;
        endcase
    end

    assign o_on        = cfg_on;
    assign o_divide_by = 7'h7F >> (3'd7 - cfg_div);

`ifdef TIMER_IRQ_REG_EN
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) o_irq <= 1'b0;
        else        o_irq <= match && cfg_ie;
    end
`else
    assign o_irq = match && cfg_ie;
`endif
endmodule

// File: tb/tb_timer_compare_unit.sv
// Randomized + directed bench for timer_compare_unit against a register-level reference model.
module tb_timer_compare_unit;
    logic       i_clk = 1'b0;
    logic       i_arst;
    logic       i_tick;
    logic       o_on;
    logic [6:0] o_divide_by;
    logic       o_irq;

    timer_compare_unit_if bus();

    timer_compare_unit #(.CNT_W(32)) dut (
        .i_clk       (i_clk),
        .i_arst      (i_arst),
        .i_tick      (i_tick),
        .bus         (bus),
        .o_on        (o_on),
        .o_divide_by (o_divide_by),
        .o_irq       (o_irq)
    );

    always #5 i_clk = ~i_clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Reference model: the programmer-visible registers, updated by the spec's rules.
    bit        m_on, m_auto, m_ie, m_match, m_irq_q;
    bit [2:0]  m_div;
    bit [31:0] m_count, m_compare;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_auto = 0; m_ie = 0; m_div = 0;
        m_count = 0; m_compare = 0; m_match = 0; m_irq_q = 0;
    endtask

    task automatic model_edge(input bit we, input bit [1:0] a, input bit [31:0] wd, input bit tick);
        bit        evt, hit, n_on, n_match;
        bit [31:0] n_count;
        evt     = m_on && tick;
        hit     = evt && (m_count == m_compare);
        n_count = m_count;
        if (hit) begin
            if (m_auto) n_count = 0;
        end else if (evt) begin
            n_count = m_count + 1;
        end
        if (we && a == 1) n_count = wd;
        n_on = (hit && !m_auto) ? 1'b0 : m_on;
        n_match = m_match;
        if (we && a == 3 && wd[0]) n_match = 0;
        if (hit) n_match = 1;
        m_irq_q = m_match && m_ie;
        if (we && a == 0) begin
            n_on = wd[0]; m_auto = wd[1]; m_ie = wd[2]; m_div = wd[6:4];
        end
        if (we && a == 2) m_compare = wd;
        m_on = n_on; m_count = n_count; m_match = n_match;
    endtask

    function automatic logic [31:0] exp_reg(input bit [1:0] a);
        case (a)
            2'd0:    return {25'd0, m_div, 1'b0, m_ie, m_auto, m_on};
            2'd1:    return m_count;
            2'd2:    return m_compare;
            default: return {31'd0, m_match};
        endcase
    endfunction

    function automatic bit exp_irq();
`ifdef TIMER_IRQ_REG_EN
        return m_irq_q;
`else
        return m_match && m_ie;
`endif
    endfunction

    task automatic check_state(input string tag);
        int dv;
        dv = (1 << m_div) - 1;
        chk({tag, ".on"},  32'(o_on), 32'(m_on));
        chk({tag, ".div"}, 32'(o_divide_by), 32'(dv));
        chk({tag, ".irq"}, 32'(o_irq), 32'(exp_irq()));
        for (int a = 0; a < 4; a++) begin
            bus.i_addr = 2'(a);
            #1;
            chk($sformatf("%s.reg%0d", tag, a), bus.o_rdata, exp_reg(2'(a)));
        end
    endtask

    task automatic cycle(input bit we, input bit [1:0] a, input bit [31:0] wd, input bit tick,
                         input string tag);
        bus.i_we = we; bus.i_addr = a; bus.i_wdata = wd; i_tick = tick;
        @(posedge i_clk);
        model_edge(we, a, wd, tick);
        #1;
        bus.i_we = 1'b0; i_tick = 1'b0;
        check_state(tag);
    endtask

    task automatic rd(input bit [1:0] a, output logic [31:0] d);
        bus.i_addr = a;
        #1;
        d = bus.o_rdata;
    endtask

    logic [31:0] d;

    initial begin
        i_arst = 1'b1; i_tick = 1'b0;
        bus.i_we = 1'b0; bus.i_addr = 2'd0; bus.i_wdata = 32'd0;
        model_reset();
        #2;
        check_state("rst0");
        @(negedge i_clk);
        i_arst = 1'b0;

        // Auto-reload: COUNT 1,2,3,0,... with MATCH on the 3->0 tick
        cycle(1, 2'd2, 32'd3, 0, "a.cmp");
        cycle(1, 2'd0, 32'h07, 0, "a.cfg");
        for (int i = 1; i <= 9; i++) begin
            cycle(0, 2'd0, 32'd0, 1, "a.tick");
            rd(2'd1, d);
            chk("auto.count", d, 32'(i % 4));
            if (i == 4) begin
                rd(2'd3, d);
                chk("auto.match", d, 32'd1);
            end
        end
        cycle(1, 2'd3, 32'd0, 0, "a.w0");
        rd(2'd3, d); chk("auto.w0_keeps", d, 32'd1);
        cycle(1, 2'd3, 32'd1, 0, "a.w1c");
        rd(2'd3, d); chk("auto.w1c", d, 32'd0);
        cycle(0, 2'd0, 32'd0, 0, "a.irqdrop");

        // One-shot
        cycle(1, 2'd0, 32'h00, 0, "o.stop");
        cycle(1, 2'd1, 32'd0, 0, "o.cnt");
        cycle(1, 2'd2, 32'd2, 0, "o.cmp");
        cycle(1, 2'd0, 32'h05, 0, "o.cfg");
        for (int i = 0; i < 3; i++) cycle(0, 2'd0, 32'd0, 1, "o.tick");
        rd(2'd1, d); chk("oneshot.count", d, 32'd2);
        chk("oneshot.on", 32'(o_on), 32'd0);
        rd(2'd3, d); chk("oneshot.match", d, 32'd1);
        for (int i = 0; i < 3; i++) cycle(0, 2'd0, 32'd0, 1, "o.idle");
        rd(2'd1, d); chk("oneshot.hold", d, 32'd2);
        cycle(1, 2'd3, 32'd1, 0, "o.clr");

        // Divide mapping and ON passthrough
        for (int dv = 0; dv < 8; dv++) begin
            cycle(1, 2'd0, 32'((dv << 4) | (dv & 1)), 0, "div");
            chk($sformatf("divmap%0d", dv), 32'(o_divide_by), 32'((1 << dv) - 1));
            chk($sformatf("onmap%0d", dv), 32'(o_on), 32'(dv & 1));
        end

        // Collisions
        cycle(1, 2'd2, 32'd100, 0, "c.cmp");
        cycle(1, 2'd0, 32'h03, 0, "c.cfg");
        cycle(1, 2'd1, 32'd5, 0, "c.cnt");
        cycle(1, 2'd1, 32'h10, 1, "c.wr_tick");
        rd(2'd1, d); chk("coll.count_wr_wins", d, 32'h10);
        cycle(1, 2'd1, 32'd100, 0, "c.cnt100");
        cycle(1, 2'd3, 32'd1, 1, "c.w1c_match");
        rd(2'd3, d); chk("coll.set_wins", d, 32'd1);
        cycle(1, 2'd3, 32'd1, 0, "c.clr");
        cycle(1, 2'd2, 32'd5, 0, "c.cmp5");
        cycle(1, 2'd1, 32'hFFFF_FFFF, 0, "c.max");
        cycle(0, 2'd0, 32'd0, 1, "c.wrap");
        rd(2'd1, d); chk("coll.wrap_count", d, 32'd0);
        rd(2'd3, d); chk("coll.wrap_nomatch", d, 32'd0);
        // one-shot match on the same edge as a CONFIG write: the write keeps ON
        cycle(1, 2'd1, 32'd5, 0, "c.cnt5");
        cycle(1, 2'd0, 32'h05, 0, "c.os");
        cycle(1, 2'd0, 32'h05, 1, "c.cfg_vs_clear");
        chk("coll.cfg_wins", 32'(o_on), 32'd1);
        // COMPARE write on a matching tick: old COMPARE decides
        cycle(1, 2'd3, 32'd1, 0, "c.clr2");
        cycle(1, 2'd0, 32'h03, 0, "c.auto");
        cycle(1, 2'd1, 32'd5, 0, "c.cnt5b");
        cycle(1, 2'd2, 32'd9, 1, "c.cmp_vs_tick");
        rd(2'd3, d); chk("coll.old_compare", d, 32'd1);
        rd(2'd1, d); chk("coll.old_compare_cnt", d, 32'd0);

        // Reset mid-count, checked before any clock edge
        cycle(1, 2'd2, 32'd1000, 0, "r.cmp");
        cycle(1, 2'd0, 32'h07, 0, "r.cfg");
        cycle(1, 2'd1, 32'd5, 0, "r.cnt");
        i_tick = 1'b1;
        i_arst = 1'b1;
        #1;
        chk("arst.on",  32'(o_on), 32'd0);
        chk("arst.div", 32'(o_divide_by), 32'd0);
        chk("arst.irq", 32'(o_irq), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            chk($sformatf("arst.reg%0d", a), d, 32'd0);
        end
        model_reset();
        @(negedge i_clk);
        i_arst = 1'b0; i_tick = 1'b0;

        // Random traffic biased toward small COUNT/COMPARE values so matches are frequent
        for (int n = 0; n < 1500; n++) begin
            bit        we;
            bit [1:0]  a;
            bit [31:0] wd;
            we = ($urandom_range(0, 3) == 0);
            a  = 2'($urandom_range(0, 3));
            case (a)
                2'd0: begin wd = $urandom; wd[0] = ($urandom_range(0, 3) != 0); end
                2'd1: wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3)
                                                      : 32'($urandom_range(0, 12));
                2'd2: wd = 32'($urandom_range(0, 12));
                default: wd = $urandom;
            endcase
            cycle(we, a, wd, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
